// File: rtl/ddr_ctrl_pkg.sv
// Definitions shared by the DDR read and write controllers on the MIG user interface.
// Covers controller states, MIG command codes and frame-buffer geometry.
package ddr_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    REQ  = 3'b010,
    XFER = 3'b100
  } ctrl_state_e;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  localparam int ADDR_STEP   = 8;
  localparam int DATA_W      = 256;
  localparam int ADDR_W      = 29;
  localparam int BURST_NUM   = 64;
  localparam int TOTAL_PIXEL = 1024 * 768 - 8;

endpackage

// File: rtl/ddr_addr_gen.sv
// Linear frame-buffer address counter: advances by ADDR_STEP per accepted command and
// wraps to 0 after TOTAL_PIXEL. Shared by the read and write controllers.
module ddr_addr_gen #(
  parameter int ADDR_W      = ddr_ctrl_pkg::ADDR_W,
  parameter int TOTAL_PIXEL = ddr_ctrl_pkg::TOTAL_PIXEL,
  parameter int ADDR_STEP   = ddr_ctrl_pkg::ADDR_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (adv) begin
      addr <= (addr == ADDR_W'(TOTAL_PIXEL)) ? '0 : addr + ADDR_W'(ADDR_STEP);
    end
  end

endmodule

// File: rtl/ddr_wr_ctrl.sv
// MIG write controller: arbitrates, then moves one burst of BURST_NUM beats from an FWFT FIFO
// into DDR. Define DDR_WR_FRAME_CLR_EN to add the wr_addr_clr frame-sync input.
module ddr_wr_ctrl #(
  parameter int TOTAL_PIXEL = ddr_ctrl_pkg::TOTAL_PIXEL,
  parameter int BURST_NUM   = ddr_ctrl_pkg::BURST_NUM,
  parameter int DATA_W      = ddr_ctrl_pkg::DATA_W,
  parameter int ADDR_W      = ddr_ctrl_pkg::ADDR_W
) (
  input  logic                ui_clk,
  input  logic                rst_n,
`ifdef DDR_WR_FRAME_CLR_EN
  input  logic                wr_addr_clr,
`endif
  input  logic                wr_start,
  output logic                wr_req,
  input  logic                wr_ack,
  output logic                wr_done,
  output logic                wr_busy,
  input  logic                wr_ddr_data_vld,
  input  logic [DATA_W-1:0]   wr_ddr_data,
  output logic                wr_ddr_data_req,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  input  logic                app_wdf_rdy
);

  import ddr_ctrl_pkg::*;

  localparam int CNT_W = $clog2(BURST_NUM + 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_data, cnt_cmd;
  logic             data_acc, cmd_acc, last_cmd, addr_clr;

  assign data_acc = app_wdf_wren && app_wdf_rdy;
  assign cmd_acc  = app_en && app_rdy;
  assign last_cmd = cmd_acc && (cnt_cmd == CNT_W'(BURST_NUM - 1));

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (wr_start) state_d = REQ;
      REQ:     if (wr_ack)   state_d = XFER;
      XFER:    if (last_cmd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and burst bookkeeping; wr_ack clearing wins over a new request.
  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_req   <= 1'b0;
      wr_done  <= 1'b0;
      cnt_data <= '0;
      cnt_cmd  <= '0;
    end else begin
      if (wr_ack) begin
        wr_req <= 1'b0;
      end else if (state_q == IDLE && wr_start) begin
        wr_req <= 1'b1;
      end
      wr_done <= last_cmd;
      if (last_cmd) begin
        cnt_data <= '0;
        cnt_cmd  <= '0;
      end else begin
        if (data_acc) cnt_data <= cnt_data + 1'b1;
        if (cmd_acc)  cnt_cmd  <= cnt_cmd + 1'b1;
      end
    end
  end

  assign wr_busy         = (state_q == XFER);
  assign app_wdf_wren    = wr_busy && (cnt_data < CNT_W'(BURST_NUM)) && wr_ddr_data_vld;
  assign wr_ddr_data_req = data_acc;
  assign app_wdf_data    = wr_ddr_data;
  assign app_wdf_end     = app_wdf_wren;
  assign app_wdf_mask    = '0;
  // A command may only cover a beat that has already been accepted.
  assign app_en          = wr_busy && (cnt_cmd < cnt_data);
  assign app_cmd         = CMD_WR;

`ifdef DDR_WR_FRAME_CLR_EN
  assign addr_clr = wr_addr_clr && (state_q == IDLE);
`else
  assign addr_clr = 1'b0;
`endif

  ddr_addr_gen #(
    .ADDR_W      (ADDR_W),
    .TOTAL_PIXEL (TOTAL_PIXEL),
    .ADDR_STEP   (ADDR_STEP)
  ) u_addr_gen (
    .clk   (ui_clk),
    .rst_n (rst_n),
    .clr   (addr_clr),
    .adv   (cmd_acc),
    .addr  (app_addr)
  );

endmodule

// File: tb/tb_ddr_wr_ctrl.sv
// Bench for ddr_wr_ctrl: cycle vector table for burst start and handshakes, then full bursts
// under stalls, underflow, address wrap and mid-burst reset. Uses a small frame for wrap reach.
module tb_ddr_wr_ctrl;

  localparam int DATA_W = 256;
  localparam int ADDR_W = 29;
  localparam int TP     = 760;
  localparam int BN     = 64;

  logic                ui_clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                wr_start = 1'b0;
  logic                wr_ack = 1'b0;
  logic                wr_ddr_data_vld = 1'b0;
  logic [DATA_W-1:0]   wr_ddr_data = '0;
  logic                app_rdy = 1'b0;
  logic                app_wdf_rdy = 1'b0;
  logic                wr_req, wr_done, wr_busy, wr_ddr_data_req;
  logic [2:0]          app_cmd;
  logic                app_en, app_wdf_wren, app_wdf_end;
  logic [ADDR_W-1:0]   app_addr;
  logic [DATA_W-1:0]   app_wdf_data;
  logic [DATA_W/8-1:0] app_wdf_mask;
`ifdef DDR_WR_FRAME_CLR_EN
  logic                wr_addr_clr = 1'b0;
`endif

  ddr_wr_ctrl #(.TOTAL_PIXEL(TP), .BURST_NUM(BN), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .ui_clk          (ui_clk),
    .rst_n           (rst_n),
`ifdef DDR_WR_FRAME_CLR_EN
    .wr_addr_clr     (wr_addr_clr),
`endif
    .wr_start        (wr_start),
    .wr_req          (wr_req),
    .wr_ack          (wr_ack),
    .wr_done         (wr_done),
    .wr_busy         (wr_busy),
    .wr_ddr_data_vld (wr_ddr_data_vld),
    .wr_ddr_data     (wr_ddr_data),
    .wr_ddr_data_req (wr_ddr_data_req),
    .app_cmd         (app_cmd),
    .app_en          (app_en),
    .app_addr        (app_addr),
    .app_rdy         (app_rdy),
    .app_wdf_data    (app_wdf_data),
    .app_wdf_wren    (app_wdf_wren),
    .app_wdf_end     (app_wdf_end),
    .app_wdf_mask    (app_wdf_mask),
    .app_wdf_rdy     (app_wdf_rdy)
  );

  always #5 ui_clk = ~ui_clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] fifo_word(input int i);
    return {8{32'hA500_0000 + 32'(i)}};
  endfunction

  // FIFO / ready driver and scoreboard state
  bit                drv_en = 0, rdy_toggle = 0, gap_en = 0, pop_seen = 0;
  int                cyc = 0, stall_s = -100, gap_cnt = 0, fifo_idx = 0;
  int                beats = 0, cmds = 0, dones = 0, wraps = 0, first_addr = -1;
  logic [ADDR_W-1:0] exp_addr = '0;

  always @(posedge ui_clk) begin
    #2;
    cyc++;
    if (pop_seen) begin
      fifo_idx++;
      pop_seen = 0;
    end
    if (drv_en) begin
      wr_ddr_data = fifo_word(fifo_idx);
      if (gap_en && beats == 10 && gap_cnt < 10) begin
        wr_ddr_data_vld = 1'b0;
        gap_cnt++;
      end else begin
        wr_ddr_data_vld = 1'b1;
      end
      app_rdy     = rdy_toggle ? cyc[0] : 1'b1;
      app_wdf_rdy = !(cyc >= stall_s && cyc < stall_s + 5);
    end
  end

  bit                mon_en = 0, en_stall_q = 0, wdf_stall_q = 0, last_q = 0, tp_q = 0;
  logic [ADDR_W-1:0] addr_q = '0;

  always @(negedge ui_clk) begin
    if (mon_en) begin
      chk("pop", wr_ddr_data_req, app_wdf_wren && app_wdf_rdy);
      chk("done_timing", wr_done, last_q);
      chk("wdf_end", app_wdf_end, app_wdf_wren);
      chk("app_cmd", app_cmd, 3'b000);
      chk("wdf_mask", app_wdf_mask, '0);
      if (wr_done) dones++;
      if (!wr_ddr_data_vld) chk("underflow_wren", app_wdf_wren, 1'b0);
      if (app_wdf_wren || app_en) chk("busy", wr_busy, 1'b1);
      if (en_stall_q) begin
        chk("en_hold", app_en, 1'b1);
        chk("addr_hold", app_addr, addr_q);
      end
      if (wdf_stall_q && wr_ddr_data_vld) chk("wren_hold", app_wdf_wren, 1'b1);
      last_q = 0;
      if (app_en && app_rdy) begin
        chk("cmd_after_data", cmds < beats, 1'b1);
        chk("cmd_addr", app_addr, exp_addr);
        if (cmds == 0) first_addr = int'(app_addr);
        if (tp_q) begin
          chk("wrap_zero", app_addr, '0);
          wraps++;
        end
        tp_q = (app_addr == ADDR_W'(TP));
        exp_addr = (exp_addr == ADDR_W'(TP)) ? '0 : exp_addr + ADDR_W'(8);
        cmds++;
        last_q = (cmds == BN);
      end
      if (app_wdf_wren && app_wdf_rdy) begin
        chk("wdata", app_wdf_data, fifo_word(fifo_idx));
        beats++;
        pop_seen = 1;
      end
      en_stall_q  = app_en && !app_rdy;
      wdf_stall_q = app_wdf_wren && !app_wdf_rdy;
      addr_q      = app_addr;
    end
  end

  task automatic kick();
    beats = 0; cmds = 0; dones = 0; gap_cnt = 0; first_addr = -1;
    @(posedge ui_clk); #3 wr_start = 1'b1;
    @(posedge ui_clk); #3 wr_start = 1'b0;
    @(posedge ui_clk); #3 wr_ack = 1'b1;
    @(posedge ui_clk); #3 wr_ack = 1'b0;
  endtask

  task automatic run_burst(input string nm);
    kick();
    for (int i = 0; i < 3000; i++) begin
      @(posedge ui_clk);
      if (dones != 0) break;
    end
    repeat (2) @(posedge ui_clk);
    @(negedge ui_clk);
    chk({nm, "_beats"}, beats, BN);
    chk({nm, "_cmds"}, cmds, BN);
    chk({nm, "_dones"}, dones, 1);
    chk({nm, "_busy_end"}, wr_busy, 1'b0);
    chk({nm, "_req_end"}, wr_req, 1'b0);
  endtask

  task automatic all_zero(input string nm);
    chk({nm, "_req"}, wr_req, 1'b0);
    chk({nm, "_busy"}, wr_busy, 1'b0);
    chk({nm, "_done"}, wr_done, 1'b0);
    chk({nm, "_en"}, app_en, 1'b0);
    chk({nm, "_wren"}, app_wdf_wren, 1'b0);
    chk({nm, "_pop"}, wr_ddr_data_req, 1'b0);
    chk({nm, "_addr"}, app_addr, '0);
  endtask

  typedef struct {
    logic              start, ack, vld, rdy, wdf_rdy;
    logic              e_req, e_busy, e_wren, e_pop, e_en;
    logic [ADDR_W-1:0] e_addr;
  } vec_t;

  vec_t vt[13];

  initial begin
    //           st  ak  vl  rd  wr | req bsy wrn pop en  addr
    vt[0]  = '{1'b1,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b0,1'b0,1'b0,1'b0, 29'd0};
    vt[1]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0, 29'd0};
    vt[2]  = '{1'b0,1'b1,1'b1,1'b1,1'b1, 1'b1,1'b0,1'b0,1'b0,1'b0, 29'd0};
    vt[3]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0, 29'd0};
    vt[4]  = '{1'b0,1'b0,1'b1,1'b1,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b1, 29'd0};
    vt[5]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1, 29'd8};
    vt[6]  = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0, 29'd16};
    vt[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b1, 1'b0,1'b1,1'b0,1'b0,1'b0, 29'd16};
    vt[8]  = '{1'b0,1'b0,1'b1,1'b0,1'b1, 1'b0,1'b1,1'b1,1'b1,1'b0, 29'd16};
    vt[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1, 29'd16};
    vt[10] = '{1'b1,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b1, 29'd16};
    vt[11] = '{1'b0,1'b1,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0, 29'd24};
    vt[12] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 1'b0,1'b1,1'b1,1'b0,1'b0, 29'd24};

    #12;
    all_zero("reset");
    @(posedge ui_clk); #3 rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(posedge ui_clk); #3;
      wr_start = vt[i].start; wr_ack = vt[i].ack; wr_ddr_data_vld = vt[i].vld;
      app_rdy = vt[i].rdy; app_wdf_rdy = vt[i].wdf_rdy;
      @(negedge ui_clk);
      chk($sformatf("vec%0d_req", i), wr_req, vt[i].e_req);
      chk($sformatf("vec%0d_busy", i), wr_busy, vt[i].e_busy);
      chk($sformatf("vec%0d_wren", i), app_wdf_wren, vt[i].e_wren);
      chk($sformatf("vec%0d_pop", i), wr_ddr_data_req, vt[i].e_pop);
      chk($sformatf("vec%0d_en", i), app_en, vt[i].e_en);
      chk($sformatf("vec%0d_addr", i), app_addr, vt[i].e_addr);
      chk($sformatf("vec%0d_done", i), wr_done, 1'b0);
    end

    // abandon the table burst and begin scoreboarded bursts from a clean state
    @(posedge ui_clk); #4 rst_n = 1'b0;
    #1 all_zero("tbl_abort");
    wr_start = 1'b0; wr_ack = 1'b0;
    @(posedge ui_clk); #3 rst_n = 1'b1;
    exp_addr = '0; mon_en = 1; drv_en = 1;

    run_burst("basic");
    chk("basic_first_addr", first_addr, 0);
    chk("basic_end_addr", app_addr, 29'd512);

    rdy_toggle = 1; stall_s = cyc + 25;
    run_burst("bp");
    rdy_toggle = 0; stall_s = -100;
    chk("bp_end_addr", app_addr, 29'd256);
    chk("bp_wraps", wraps, 1);

    gap_en = 1;
    run_burst("uflow");
    gap_en = 0;
    chk("uflow_end_addr", app_addr, 29'd0);

    kick();
    for (int i = 0; i < 500 && beats < 30; i++) @(posedge ui_clk);
    chk("abort_reach30", beats >= 30, 1'b1);
    @(posedge ui_clk); #4 rst_n = 1'b0; mon_en = 0;
    #1 all_zero("midrst");
    @(posedge ui_clk); #3 rst_n = 1'b1;
    exp_addr = '0; tp_q = 0; last_q = 0; en_stall_q = 0; wdf_stall_q = 0;
    mon_en = 1;
    run_burst("post_rst");
    chk("post_rst_first_addr", first_addr, 0);
    chk("post_rst_end_addr", app_addr, 29'd512);

`ifdef DDR_WR_FRAME_CLR_EN
    @(posedge ui_clk); #3 wr_addr_clr = 1'b1;
    @(posedge ui_clk); #3 wr_addr_clr = 1'b0;
    @(negedge ui_clk);
    chk("clr_idle_addr", app_addr, '0);
    exp_addr = '0;
    fork
      run_burst("clr_write");
      begin
        repeat (20) @(posedge ui_clk);
        #3 wr_addr_clr = 1'b1;
        @(posedge ui_clk); #3 wr_addr_clr = 1'b0;
      end
    join
    chk("clr_write_first_addr", first_addr, 0);
    chk("clr_write_end_addr", app_addr, 29'd512);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
